// File: rtl/arb_mux.sv
// N-channel arbitrated multiplexer: round-robin or fixed-priority selection of
// valid/ready producers into one registered output word tagged with its channel.
module arb_mux #(
  parameter int W    = 16,
  parameter int N    = 4,
  parameter int MODE = 0,
  // Derived from N; leave at its default.
  parameter int CW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     out_data,
  output logic [CW-1:0]    out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [CW-1:0] ptr;
  logic [CW-1:0] base;
  logic [CW-1:0] win;
  logic [N-1:0]  grant;
  logic          found;
  logic          load;
  logic          xfer;

  // Index b+j folded back into 0..N-1; works for any N, not just powers of two.
  function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] b, input int j);
    int s;
    s = int'(b) + j;
    if (s >= N) s = s - N;
    return CW'(s);
  endfunction

  assign base = (MODE == 0) ? ptr : '0;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise the tool infers a latch.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && in_valid[wrap_idx(base, j)]) begin
        found                   = 1'b1;
        win                     = wrap_idx(base, j);
        grant[wrap_idx(base, j)] = 1'b1;
      end
    end
  end

  assign load = !out_valid || out_ready;

  // rst_n gates in_ready directly so no producer sees an accept during reset,
  // when the cleared out_valid would otherwise make load true.
  assign in_ready = (rst_n && load) ? grant : '0;
  assign xfer     = |(in_valid & in_ready);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_data  <= in_data[win*W +: W];
      out_chan  <= win;
      out_valid <= 1'b1;
      if (MODE == 0) ptr <= wrap_idx(win, 1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(in_ready));

  a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> $stable(out_data));

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: round-robin (N=4 and N=3) and fixed-priority
// instances sharing one clock and reset, checked against hand-computed values.
module tb_arb_mux;

  logic clk;
  logic rst_n;

  // Round-robin, N=4
  logic [63:0] d4;
  logic [3:0]  v4, r4;
  logic [15:0] od4;
  logic [1:0]  oc4;
  logic        ov4, or4;

  // Round-robin, N=3
  logic [47:0] d3;
  logic [2:0]  v3, r3;
  logic [15:0] od3;
  logic [1:0]  oc3;
  logic        ov3, or3;

  // Fixed priority, N=4
  logic [63:0] df;
  logic [3:0]  vf, rf;
  logic [15:0] odf;
  logic [1:0]  ocf;
  logic        ovf, orf;

  int checks;
  int failures;

  arb_mux #(.W(16), .N(4), .MODE(0)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_ready(r4),
    .out_data(od4), .out_chan(oc4), .out_valid(ov4), .out_ready(or4));

  arb_mux #(.W(16), .N(3), .MODE(0)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3), .in_ready(r3),
    .out_data(od3), .out_chan(oc3), .out_valid(ov3), .out_ready(or3));

  arb_mux #(.W(16), .N(4), .MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_data(df), .in_valid(vf), .in_ready(rf),
    .out_data(odf), .out_chan(ocf), .out_valid(ovf), .out_ready(orf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 4; i++) begin
      d4[i*16 +: 16] = 16'hA000 + 16'(i);
      df[i*16 +: 16] = 16'hD000 + 16'(i);
    end
    for (int i = 0; i < 3; i++) d3[i*16 +: 16] = 16'hC000 + 16'(i);
    v4 = 4'b1111; or4 = 1'b1;
    v3 = 3'b000;  or3 = 1'b1;
    vf = 4'b0000; orf = 1'b1;

    // Reset held with all inputs valid
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 32'(ov4), 32'h0);
    check("rst_out_data",  32'(od4), 32'h0);
    check("rst_out_chan",  32'(oc4), 32'h0);
    check("rst_in_ready",  32'(r4),  32'h0);
    #1 rst_n = 1'b1;
    #1 check("first_grant", 32'(r4), 32'b0001);

    // Round-robin rotation, one word per cycle
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rr_chan_%0d", k),  32'(oc4), 32'(k % 4));
      check($sformatf("rr_data_%0d", k),  32'(od4), 32'(16'hA000 + 16'(k % 4)));
      check($sformatf("rr_valid_%0d", k), 32'(ov4), 32'h1);
    end

    // Backpressure: load 1234 from channel 0, then stall five cycles
    d4[15:0] = 16'h1234;
    tick();
    check("bp_load_data", 32'(od4), 32'h1234);
    d4[15:0] = 16'hA000;
    or4 = 1'b0;
    #1 check("bp_in_ready", 32'(r4), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_hold_data_%0d", k), 32'(od4), 32'h1234);
      check($sformatf("bp_hold_chan_%0d", k), 32'(oc4), 32'h0);
      check($sformatf("bp_in_ready_%0d", k),  32'(r4),  32'h0);
    end
    or4 = 1'b1;
    #1 check("bp_release_ready", 32'(r4), 32'b0010);
    tick();
    check("bp_refill_chan", 32'(oc4), 32'h1);
    check("bp_refill_data", 32'(od4), 32'hA001);
    check("bp_refill_valid", 32'(ov4), 32'h1);

    // Bubble: single pulse on channel 2
    v4 = 4'b0100;
    d4[47:32] = 16'hBEEF;
    #1 check("bub_ready", 32'(r4), 32'b0100);
    tick();
    v4 = 4'b0000;
    check("bub_valid", 32'(ov4), 32'h1);
    check("bub_chan",  32'(oc4), 32'h2);
    check("bub_data",  32'(od4), 32'hBEEF);
    tick();
    check("bub_drain_valid", 32'(ov4), 32'h0);
    check("bub_drain_data",  32'(od4), 32'hBEEF);

    // Asynchronous reset while a word is pending
    v4 = 4'b0001;
    tick();
    v4 = 4'b0000;
    check("ar_pending", 32'(ov4), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid_clear", 32'(ov4), 32'h0);
    check("ar_data_clear",  32'(od4), 32'h0);
    check("ar_in_ready",    32'(r4),  32'h0);
    #2 rst_n = 1'b1;
    v4 = 4'b1010;
    #1 check("ar_first_grant", 32'(r4), 32'b0010);
    tick();
    v4 = 4'b0000;
    check("ar_first_chan", 32'(oc4), 32'h1);

    // N=3 skip and wrap
    v3 = 3'b100;
    #1 check("n3_grant2", 32'(r3), 32'b100);
    tick();
    check("n3_chan2", 32'(oc3), 32'h2);
    v3 = 3'b011;
    #1 check("n3_wrap_ready", 32'(r3), 32'b001);
    tick();
    check("n3_chan0", 32'(oc3), 32'h0);
    check("n3_data0", 32'(od3), 32'hC000);
    check("n3_next_ready", 32'(r3), 32'b010);
    tick();
    check("n3_chan1", 32'(oc3), 32'h1);
    v3 = 3'b111;
    #1 check("n3_ptr2_ready", 32'(r3), 32'b100);
    tick();
    check("n3_chan2b", 32'(oc3), 32'h2);
    check("n3_wrap0_ready", 32'(r3), 32'b001);
    v3 = 3'b000;

    // Fixed priority
    vf = 4'b1010;
    #1 check("fp_ready1", 32'(rf), 32'b0010);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("fp_chan1_%0d", k), 32'(ocf), 32'h1);
      check($sformatf("fp_data1_%0d", k), 32'(odf), 32'hD001);
    end
    vf = 4'b1000;
    #1 check("fp_ready3", 32'(rf), 32'b1000);
    tick();
    check("fp_chan3", 32'(ocf), 32'h3);
    check("fp_data3", 32'(odf), 32'hD003);
    vf = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
